// File: rtl/acc28_pkg.sv
// Shared definitions for the 28-bit windowed accumulator: input width,
// FSM state encoding and the output-width derivation.
package acc28_pkg;

  localparam int IN_W = 28;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // A window of 2^nlog2 full-scale 28-bit sums needs nlog2 extra bits.
  function automatic int acc_ow(input int nlog2);
    return IN_W + nlog2;
  endfunction

endpackage

// File: rtl/acc28_win.sv
// Sums 2^NLOG2 consecutive valid adder outputs and presents each window total
// through a one-entry valid/ready holding register with a sticky drop flag.
module acc28_win
  import acc28_pkg::*;
#(
  parameter int NLOG2 = 4,
  parameter int OW    = acc_ow(NLOG2)
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               SCLR,
  input  logic [IN_W-1:0]    S_IN,
  input  logic               S_VLD,
  output logic [OW-1:0]      SUM,
  output logic               SUM_VLD,
  input  logic               SUM_RDY,
  output logic               DROP,
  output logic [NLOG2-1:0]   WCNT
);

  localparam logic [NLOG2-1:0] WLAST = '1;

  state_t            r_state, w_state_nxt;
  logic [OW-1:0]     r_acc, w_acc_nxt, w_result;
  logic [NLOG2-1:0]  r_wcnt, w_wcnt_nxt;
  logic [OW-1:0]     r_sum;
  logic              r_sum_vld, r_drop;
  logic              w_done, w_take, w_load;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_wcnt_nxt  = r_wcnt;
    w_done      = 1'b0;
    w_result    = r_acc + OW'(S_IN);
    case (r_state)
      IDLE: begin
        if (S_VLD) begin
          w_state_nxt = ACC;
          w_acc_nxt   = OW'(S_IN);
          w_wcnt_nxt  = NLOG2'(1);
        end
      end
      ACC: begin
        if (S_VLD) begin
          if (r_wcnt == WLAST) begin
            // Window closes here; the next sample opens a new one directly.
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_wcnt_nxt  = '0;
          end else begin
            w_acc_nxt   = w_result;
            w_wcnt_nxt  = r_wcnt + NLOG2'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_take = r_sum_vld & SUM_RDY;
  assign w_load = w_done & (~r_sum_vld | SUM_RDY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_wcnt    <= '0;
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
      r_drop    <= 1'b0;
    end else if (SCLR) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_wcnt    <= '0;
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_load) begin
        r_sum     <= w_result;
        r_sum_vld <= 1'b1;
      end else if (w_take) begin
        r_sum_vld <= 1'b0;
      end
      // Holding register is full and not being drained: result is lost.
      if (w_done && !w_load) r_drop <= 1'b1;
    end
  end

  assign SUM     = r_sum;
  assign SUM_VLD = r_sum_vld;
  assign DROP    = r_drop;
  assign WCNT    = r_wcnt;

endmodule

// File: tb/tb_acc28_win.sv
// Directed bench for acc28_win with a 4-sample window and hand-computed results.
module tb_acc28_win;

  localparam int NLOG2 = 2;
  localparam int OW    = 28 + NLOG2;

  logic             CLK;
  logic             RSTN;
  logic             SCLR;
  logic [27:0]      S_IN;
  logic             S_VLD;
  logic [OW-1:0]    SUM;
  logic             SUM_VLD;
  logic             SUM_RDY;
  logic             DROP;
  logic [NLOG2-1:0] WCNT;

  int checks = 0;
  int errors = 0;

  acc28_win #(.NLOG2(NLOG2)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .SCLR    (SCLR),
    .S_IN    (S_IN),
    .S_VLD   (S_VLD),
    .SUM     (SUM),
    .SUM_VLD (SUM_VLD),
    .SUM_RDY (SUM_RDY),
    .DROP    (DROP),
    .WCNT    (WCNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic vld, input logic [27:0] din, input logic rdy, input logic clr);
    S_VLD   = vld;
    S_IN    = din;
    SUM_RDY = rdy;
    SCLR    = clr;
    @(posedge CLK);
    #1;
    S_VLD = 1'b0;
    SCLR  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; SCLR = 1'b0; S_IN = '0; S_VLD = 1'b0; SUM_RDY = 1'b0;
    #12;
    check("rst_sum",  64'(SUM), 64'd0);
    check("rst_vld",  64'(SUM_VLD), 64'd0);
    check("rst_drop", 64'(DROP), 64'd0);
    check("rst_wcnt", 64'(WCNT), 64'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // Basic window 1+2+3+4 with consumer always ready.
    cyc(1'b1, 28'd1, 1'b1, 1'b0); check("t1_wcnt1", 64'(WCNT), 64'd1);
    cyc(1'b1, 28'd2, 1'b1, 1'b0); check("t1_wcnt2", 64'(WCNT), 64'd2);
    check("t1_novld", 64'(SUM_VLD), 64'd0);
    cyc(1'b1, 28'd3, 1'b1, 1'b0); check("t1_wcnt3", 64'(WCNT), 64'd3);
    cyc(1'b1, 28'd4, 1'b1, 1'b0); check("t1_wcnt0", 64'(WCNT), 64'd0);
    check("t1_sum", 64'(SUM), 64'd10);
    check("t1_vld", 64'(SUM_VLD), 64'd1);
    cyc(1'b0, 28'd0, 1'b1, 1'b0);
    check("t1_taken", 64'(SUM_VLD), 64'd0);
    check("t1_hold",  64'(SUM), 64'd10);
    cyc(1'b0, 28'd9, 1'b1, 1'b0);
    check("t1_idle_wcnt", 64'(WCNT), 64'd0);

    // Full-scale back-to-back windows, no bubble.
    for (int i = 0; i < 4; i++) cyc(1'b1, 28'hFFFFFFF, 1'b1, 1'b0);
    check("t2_sum_a", 64'(SUM), 64'h3FFFFFFC);
    check("t2_vld_a", 64'(SUM_VLD), 64'd1);
    cyc(1'b1, 28'hFFFFFFF, 1'b1, 1'b0);
    check("t2_wcnt1", 64'(WCNT), 64'd1);
    check("t2_taken", 64'(SUM_VLD), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 28'hFFFFFFF, 1'b1, 1'b0);
    check("t2_sum_b", 64'(SUM), 64'h3FFFFFFC);
    check("t2_vld_b", 64'(SUM_VLD), 64'd1);
    check("t2_drop",  64'(DROP), 64'd0);
    cyc(1'b0, 28'd0, 1'b1, 1'b0);
    check("t2_drain", 64'(SUM_VLD), 64'd0);

    // Transfer and new load on the same edge.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 28'(i), 1'b0, 1'b0);
    check("t3_sum_a", 64'(SUM), 64'd10);
    for (int i = 5; i <= 7; i++) cyc(1'b1, 28'(i), 1'b0, 1'b0);
    check("t3_stall_sum", 64'(SUM), 64'd10);
    check("t3_stall_vld", 64'(SUM_VLD), 64'd1);
    cyc(1'b1, 28'd8, 1'b1, 1'b0);
    check("t3_sum_b", 64'(SUM), 64'd26);
    check("t3_vld_b", 64'(SUM_VLD), 64'd1);
    check("t3_drop",  64'(DROP), 64'd0);
    cyc(1'b0, 28'd0, 1'b1, 1'b0);
    check("t3_drain", 64'(SUM_VLD), 64'd0);

    // Window completes while holding register is stalled: dropped.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 28'(i), 1'b0, 1'b0);
    for (int i = 5; i <= 8; i++) cyc(1'b1, 28'(i), 1'b0, 1'b0);
    check("t4_sum",  64'(SUM), 64'd10);
    check("t4_vld",  64'(SUM_VLD), 64'd1);
    check("t4_drop", 64'(DROP), 64'd1);
    cyc(1'b0, 28'd0, 1'b1, 1'b0);
    check("t4_taken", 64'(SUM_VLD), 64'd0);
    check("t4_hold",  64'(SUM), 64'd10);
    check("t4_sticky", 64'(DROP), 64'd1);
    cyc(1'b0, 28'd0, 1'b0, 1'b1);
    check("t4_clr_drop", 64'(DROP), 64'd0);
    check("t4_clr_sum",  64'(SUM), 64'd0);

    // Asynchronous reset mid-window discards the partial sum.
    cyc(1'b1, 28'd100, 1'b1, 1'b0);
    cyc(1'b1, 28'd200, 1'b1, 1'b0);
    check("t5_wcnt2", 64'(WCNT), 64'd2);
    RSTN = 1'b0;
    #2;
    check("t5_async_wcnt", 64'(WCNT), 64'd0);
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 28'd5, 1'b1, 1'b0);
    check("t5_sum", 64'(SUM), 64'd20);
    check("t5_vld", 64'(SUM_VLD), 64'd1);

    // Synchronous clear coinciding with the closing sample.
    cyc(1'b1, 28'd1, 1'b1, 1'b0);
    cyc(1'b1, 28'd2, 1'b1, 1'b0);
    cyc(1'b1, 28'd3, 1'b1, 1'b0);
    cyc(1'b1, 28'd4, 1'b1, 1'b1);
    check("t6_vld",  64'(SUM_VLD), 64'd0);
    check("t6_wcnt", 64'(WCNT), 64'd0);
    check("t6_sum",  64'(SUM), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 28'(i), 1'b1, 1'b0);
    check("t6_sum_after", 64'(SUM), 64'd10);
    check("t6_vld_after", 64'(SUM_VLD), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
